// File: rtl/reg_writeback_queue_pkg.sv
// Shared constants for the CRP16 register write-back path.
// Register-bank geometry shared by the write-back queue and the register bank.
package reg_writeback_queue_pkg;
   localparam int CRP16_DATA_W      = 16;
   localparam int CRP16_NUM_REGS    = 8;
   localparam int CRP16_REG_IDX_W   = 3;
   localparam int WBQ_DEFAULT_DEPTH = 4;
endpackage

// File: rtl/reg_writeback_queue_decoder.sv
// reg_index_decoder: turns a register index into a one-hot write-enable
// vector, gated by en. Also reused by the register-bank top level.
module reg_index_decoder
   import reg_writeback_queue_pkg::*;
#(
   parameter int NUM_REGS = CRP16_NUM_REGS,
   localparam int IDX_W   = $clog2(NUM_REGS)
) (
   input  logic                en,
   input  logic [IDX_W-1:0]    idx,
   output logic [NUM_REGS-1:0] onehot
);
   // One comparator per register; only the addressed one is set when en is high.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign onehot[gi] = en && (idx == IDX_W'(gi));
   end
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: FIFO of register write-back requests. It drains one
// entry per cycle into the register bank through load_val and write_en.
// Optional feature macro: WBQ_BYPASS_EN enables the youngest-match lookup
// on rd_reg. Without it, rd_hit and rd_val are tied to zero.
module reg_writeback_queue
   import reg_writeback_queue_pkg::*;
#(
   parameter int DEPTH    = WBQ_DEFAULT_DEPTH,
   parameter int NUM_REGS = CRP16_NUM_REGS,
   parameter int DATA_W   = CRP16_DATA_W,
   localparam int IDX_W   = $clog2(NUM_REGS),
   localparam int PTR_W   = $clog2(DEPTH)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                push,
   input  logic [IDX_W-1:0]    push_reg,
   input  logic [DATA_W-1:0]   push_val,
   input  logic                hold,
   output logic                full,
   output logic                empty,
   output logic                overflow,
   output logic [DATA_W-1:0]   load_val,
   output logic [NUM_REGS-1:0] write_en,
   input  logic [IDX_W-1:0]    rd_reg,
   output logic                rd_hit,
   output logic [DATA_W-1:0]   rd_val
);
   logic [IDX_W-1:0]  entry_reg_q [DEPTH];
   logic [DATA_W-1:0] entry_val_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic push_accept;
   logic pop;

   // full and empty come from the registered count, so a pop in the same
   // cycle never frees a slot for a push arriving while full.
   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign overflow = overflow_q;

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      push_accept = push && !full;
      pop         = !empty && !hold;
      wr_ptr_d    = wr_ptr_q + PTR_W'(push_accept);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      overflow_d  = overflow_q | (push && full);
      count_d     = count_q;
      if (push_accept && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push_accept) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control state; reset discards every pending entry.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clock) begin
      if (push_accept) begin
         entry_reg_q[wr_ptr_q] <= push_reg;
         entry_val_q[wr_ptr_q] <= push_val;
      end
   end

   // Head value goes to every register; zero when nothing drains.
   assign load_val = pop ? entry_val_q[rd_ptr_q] : '0;

   reg_index_decoder #(
      .NUM_REGS (NUM_REGS)
   ) u_dec (
      .en     (pop),
      .idx    (entry_reg_q[rd_ptr_q]),
      .onehot (write_en)
   );

`ifdef WBQ_BYPASS_EN
   logic [PTR_W-1:0] slot;

   // Walk entries oldest to youngest so the last match wins (youngest value).
   always_comb begin
      rd_hit = 1'b0;
      rd_val = '0;
      slot   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr_q + PTR_W'(i);
         if ((i < int'(count_q)) && (entry_reg_q[slot] == rd_reg)) begin
            rd_hit = 1'b1;
            rd_val = entry_val_q[slot];
         end
      end
   end
`else
   // Lookup disabled: keep the ports for a stable interface.
   logic unused_rd_reg;
   assign unused_rd_reg = ^rd_reg;
   assign rd_hit        = 1'b0;
   assign rd_val        = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed testbench for reg_writeback_queue (default parameters).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_reg_writeback_queue;
   logic        clock;
   logic        reset_n;
   logic        push;
   logic [2:0]  push_reg;
   logic [15:0] push_val;
   logic        hold;
   logic        full;
   logic        empty;
   logic        overflow;
   logic [15:0] load_val;
   logic [7:0]  write_en;
   logic [2:0]  rd_reg;
   logic        rd_hit;
   logic [15:0] rd_val;

   int tests_run;
   int tests_failed;

   reg_writeback_queue dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (push),
      .push_reg (push_reg),
      .push_val (push_val),
      .hold     (hold),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .load_val (load_val),
      .write_en (write_en),
      .rd_reg   (rd_reg),
      .rd_hit   (rd_hit),
      .rd_val   (rd_val)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronise to the falling edge, then drive a fresh reset pulse.
   task automatic apply_reset();
      @(negedge clock);
      push    = 1'b0;
      hold    = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Present one push for a single rising edge; returns at the next falling edge.
   task automatic push_one(input logic [2:0] r, input logic [15:0] v);
      push     = 1'b1;
      push_reg = r;
      push_val = v;
      @(negedge clock);
      push     = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      tests_run++;
      if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: empty=%b full=%b overflow=%b, required 1 0 0", empty, full, overflow);
      end
      tests_run++;
      if (write_en !== 8'h00 || load_val !== 16'h0000 || rd_hit !== 1'b0 || rd_val !== 16'h0000) begin
         tests_failed++;
         $display("FAIL reset_outputs: write_en=%h load_val=%h rd_hit=%b rd_val=%h, required all 0",
                  write_en, load_val, rd_hit, rd_val);
      end
      // Fill past capacity, then reset asynchronously between edges.
      @(negedge clock);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) push_one(3'(i), 16'h0100 + 16'(i));
      hold = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      tests_run++;
      if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || write_en !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_async: empty=%b full=%b overflow=%b write_en=%h, required 1 0 0 00",
                  empty, full, overflow, write_en);
      end
      $display("[TB] reset: async clear checked");
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      apply_reset();
      push_one(3'd3, 16'hBEEF);
      #1;
      tests_run++;
      if (write_en !== 8'b0000_1000 || load_val !== 16'hBEEF || empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_drain: write_en=%b load_val=%h empty=%b, required 00001000 beef 0",
                  write_en, load_val, empty);
      end
      @(negedge clock);
      #1;
      tests_run++;
      if (empty !== 1'b1 || write_en !== 8'h00 || load_val !== 16'h0000) begin
         tests_failed++;
         $display("FAIL single_after: empty=%b write_en=%h load_val=%h, required 1 00 0000",
                  empty, write_en, load_val);
      end
      $display("[TB] single: r3 <= beef");
   endtask

   task automatic test_fill_overflow();
      apply_reset();
      hold = 1'b1;
      for (int i = 0; i < 4; i++) push_one(3'(i), 16'h1000 + 16'(i));
      #1;
      tests_run++;
      if (full !== 1'b1 || overflow !== 1'b0 || write_en !== 8'h00) begin
         tests_failed++;
         $display("FAIL fill_full: full=%b overflow=%b write_en=%h, required 1 0 00", full, overflow, write_en);
      end
      push_one(3'd4, 16'h1004);
      #1;
      tests_run++;
      if (overflow !== 1'b1 || full !== 1'b1) begin
         tests_failed++;
         $display("FAIL fill_overflow: overflow=%b full=%b, required 1 1", overflow, full);
      end
      hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         tests_run++;
         if (write_en !== (8'd1 << k) || load_val !== 16'h1000 + 16'(k)) begin
            tests_failed++;
            $display("FAIL fill_drain%0d: write_en=%b load_val=%h, required %b %h",
                     k, write_en, load_val, 8'd1 << k, 16'h1000 + 16'(k));
         end
         @(negedge clock);
      end
      #1;
      tests_run++;
      if (empty !== 1'b1 || overflow !== 1'b1 || write_en !== 8'h00) begin
         tests_failed++;
         $display("FAIL fill_end: empty=%b overflow=%b write_en=%h, required 1 1 00", empty, overflow, write_en);
      end
      $display("[TB] fill/overflow: 4 drained in order, 5th dropped");
   endtask

   task automatic test_simultaneous();
      logic [2:0]  exp_r [3];
      logic [15:0] exp_v [3];
      apply_reset();
      hold = 1'b1;
      push_one(3'd1, 16'h0011);
      push_one(3'd2, 16'h0022);
      // count = 2: push r3 while r1 drains.
      hold     = 1'b0;
      push     = 1'b1;
      push_reg = 3'd3;
      push_val = 16'h0033;
      #1;
      tests_run++;
      if (write_en !== 8'b0000_0010 || load_val !== 16'h0011) begin
         tests_failed++;
         $display("FAIL simul_pop: write_en=%b load_val=%h, required 00000010 0011", write_en, load_val);
      end
      @(negedge clock);
      push = 1'b0;
      exp_r = '{3'd2, 3'd3, 3'd0};
      exp_v = '{16'h0022, 16'h0033, 16'h0000};
      for (int k = 0; k < 2; k++) begin
         #1;
         tests_run++;
         if (write_en !== (8'd1 << exp_r[k]) || load_val !== exp_v[k]) begin
            tests_failed++;
            $display("FAIL simul_order%0d: write_en=%b load_val=%h, required %b %h",
                     k, write_en, load_val, 8'd1 << exp_r[k], exp_v[k]);
         end
         @(negedge clock);
      end
      #1;
      tests_run++;
      if (empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_count2: empty=%b, required 1", empty);
      end
      // Full: push while popping must still be rejected.
      hold = 1'b1;
      for (int i = 4; i < 8; i++) push_one(3'(i), 16'h0044 + 16'h0011 * 16'(i - 4));
      hold     = 1'b0;
      push     = 1'b1;
      push_reg = 3'd0;
      push_val = 16'h0099;
      #1;
      tests_run++;
      if (full !== 1'b1 || write_en !== 8'b0001_0000 || load_val !== 16'h0044) begin
         tests_failed++;
         $display("FAIL simul_full: full=%b write_en=%b load_val=%h, required 1 00010000 0044",
                  full, write_en, load_val);
      end
      @(negedge clock);
      push = 1'b0;
      #1;
      tests_run++;
      if (full !== 1'b0 || overflow !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_drop: full=%b overflow=%b, required 0 1", full, overflow);
      end
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (write_en !== (8'd1 << (k + 5)) || load_val !== 16'h0055 + 16'h0011 * 16'(k)) begin
            tests_failed++;
            $display("FAIL simul_rest%0d: write_en=%b load_val=%h, required %b %h",
                     k, write_en, load_val, 8'd1 << (k + 5), 16'h0055 + 16'h0011 * 16'(k));
         end
         @(negedge clock);
         #1;
      end
      tests_run++;
      if (empty !== 1'b1 || write_en !== 8'h00) begin
         tests_failed++;
         $display("FAIL simul_end: empty=%b write_en=%h, required 1 00 (dropped push drained)", empty, write_en);
      end
      $display("[TB] simultaneous: count held, full push dropped");
   endtask

   task automatic test_bypass();
      logic        exp_hit;
      logic [15:0] exp_val;
      apply_reset();
      hold = 1'b1;
      push_one(3'd2, 16'h0001);
      push_one(3'd2, 16'h0002);
      push_one(3'd5, 16'h0055);
      rd_reg = 3'd2;
      #1;
`ifdef WBQ_BYPASS_EN
      exp_hit = 1'b1;
      exp_val = 16'h0002;
`else
      exp_hit = 1'b0;
      exp_val = 16'h0000;
`endif
      tests_run++;
      if (rd_hit !== exp_hit || rd_val !== exp_val) begin
         tests_failed++;
         $display("FAIL bypass_youngest: rd_hit=%b rd_val=%h, required %b %h", rd_hit, rd_val, exp_hit, exp_val);
      end
      rd_reg = 3'd4;
      #1;
      tests_run++;
      if (rd_hit !== 1'b0 || rd_val !== 16'h0000) begin
         tests_failed++;
         $display("FAIL bypass_miss: rd_hit=%b rd_val=%h, required 0 0000", rd_hit, rd_val);
      end
      // Drain everything; a same-cycle push into the empty queue is not searched.
      hold = 1'b0;
      repeat (3) @(negedge clock);
      push     = 1'b1;
      push_reg = 3'd6;
      push_val = 16'h0066;
      rd_reg   = 3'd6;
      #1;
      tests_run++;
      if (rd_hit !== 1'b0 || empty !== 1'b1) begin
         tests_failed++;
         $display("FAIL bypass_push_same_cycle: rd_hit=%b empty=%b, required 0 1", rd_hit, empty);
      end
      @(negedge clock);
      push = 1'b0;
      hold = 1'b1;
      #1;
`ifdef WBQ_BYPASS_EN
      exp_val = 16'h0066;
`endif
      tests_run++;
      if (rd_hit !== exp_hit || rd_val !== exp_val) begin
         tests_failed++;
         $display("FAIL bypass_head: rd_hit=%b rd_val=%h, required %b %h", rd_hit, rd_val, exp_hit, exp_val);
      end
      hold   = 1'b0;
      rd_reg = 3'd0;
      @(negedge clock);
      $display("[TB] bypass: lookup checked (hit expected=%b)", exp_hit);
   endtask

   task automatic test_wrap();
      logic [2:0]  r;
      logic [15:0] v;
      apply_reset();
      for (int i = 0; i <= 10; i++) begin
         push = (i < 10);
         if (i < 10) begin
            push_reg = 3'((i * 3) % 8);
            push_val = 16'hA000 + 16'h0111 * 16'(i);
         end
         #1;
         if (i > 0) begin
            r = 3'(((i - 1) * 3) % 8);
            v = 16'hA000 + 16'h0111 * 16'(i - 1);
            tests_run++;
            if (write_en !== (8'd1 << r) || load_val !== v) begin
               tests_failed++;
               $display("FAIL wrap%0d: write_en=%b load_val=%h, required %b %h",
                        i - 1, write_en, load_val, 8'd1 << r, v);
            end
         end
         @(negedge clock);
      end
      push = 1'b0;
      #1;
      tests_run++;
      if (empty !== 1'b1 || overflow !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_end: empty=%b overflow=%b, required 1 0", empty, overflow);
      end
      $display("[TB] wrap: 10 push/drain cycles");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset_n      = 1'b0;
      push         = 1'b0;
      push_reg     = 3'd0;
      push_val     = 16'h0000;
      hold         = 1'b0;
      rd_reg       = 3'd0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_simultaneous();
      test_bypass();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
